// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write/read arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } wr_state_e;

  localparam int unsigned DefDwidth = 8;
  localparam int unsigned DefNreq   = 4;
  localparam int unsigned DefBurst  = 4;

  // Wide enough for the largest allowed burst (15).
  localparam int unsigned BeatW     = 4;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Round-robin picker: first asserted request at or after start, wrapping at N-1.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] start,
  output logic [N-1:0]    gnt,
  output logic            valid
);

  logic            found;
  logic [PtrW:0]   sum;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum = {1'b0, start} + (PtrW + 1)'(i);
      if (sum >= (PtrW + 1)'(N)) begin
        sum = sum - (PtrW + 1)'(N);
      end
      idx = sum[PtrW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/fifo_arb.sv
// Arbitrates NREQ burst-limited round-robin writers and one reader onto a single-port FIFO.
module fifo_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DWIDTH = DefDwidth,
  parameter int unsigned NREQ   = DefNreq,
  parameter int unsigned BURST  = DefBurst
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        wr_req,
  input  logic [NREQ*DWIDTH-1:0] wr_data,
  output logic [NREQ-1:0]        wr_gnt,
  input  logic                   rd_req,
  output logic                   rd_ack,
  output logic                   rd_valid,
  output logic                   fifo_en,
  output logic                   fifo_wr,
  output logic                   fifo_rd,
  output logic [DWIDTH-1:0]      fifo_din,
  input  logic                   fifo_full,
  input  logic                   fifo_empty
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wr_state_e       state_q, state_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0] beats_q, beats_d;
  logic            turn_q, turn_d;
  logic            rd_valid_q;

  logic            own_keep;
  logic [PtrW-1:0] start_ptr;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_valid;
  logic [NREQ-1:0] own_gnt;
  logic [NREQ-1:0] win_gnt;
  logic [PtrW-1:0] win_idx;
  logic            write_elig, read_elig, contend;
  logic            do_write, do_read;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Once the owner is done, the search starts just past it so the hand-off costs no cycle.
  assign own_keep  = (state_q == StOwn) && wr_req[owner_q] && (beats_q < BeatW'(BURST));
  assign start_ptr = (state_q == StOwn) ? next_ptr(owner_q) : rr_ptr_q;

  rr_pick #(
    .N (NREQ)
  ) u_rr_pick (
    .req   (wr_req),
    .start (start_ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    own_gnt          = '0;
    own_gnt[owner_q] = 1'b1;
    win_gnt          = own_keep ? own_gnt : pick_gnt;
    win_idx          = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_gnt[i]) begin
        win_idx = PtrW'(i);
      end
    end
  end

  assign write_elig = pick_valid && !fifo_full;
  assign read_elig  = rd_req && !fifo_empty;
  assign contend    = write_elig && read_elig;
  assign do_write   = !rst && write_elig && (!read_elig || !turn_q);
  assign do_read    = !rst && read_elig && (!write_elig || turn_q);

  assign wr_gnt   = do_write ? win_gnt : '0;
  assign rd_ack   = do_read;
  assign fifo_wr  = do_write;
  assign fifo_rd  = do_read;
  assign fifo_en  = do_write | do_read;
  assign rd_valid = rd_valid_q;

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (wr_gnt[i]) begin
        fifo_din = wr_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    beats_d  = beats_q;
    rr_ptr_d = rr_ptr_q;
    turn_d   = contend ? ~turn_q : turn_q;
    if ((state_q == StOwn) && !own_keep) begin
      state_d  = StIdle;
      rr_ptr_d = next_ptr(owner_q);
    end
    if (do_write) begin
      if (own_keep) begin
        beats_d = beats_q + 1'b1;
      end else begin
        state_d = StOwn;
        owner_d = win_idx;
        beats_d = BeatW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beats_q    <= '0;
      turn_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beats_q    <= beats_d;
      turn_q     <= turn_d;
      rd_valid_q <= do_read;
    end
  end

endmodule

// File: tb/tb_fifo_arb.sv
// Directed bench for fifo_arb with a counting FIFO model supplying full/empty.
module tb_fifo_arb;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  wr_req = 4'hF;
  logic [NR*DW-1:0] wr_data;
  logic [NR-1:0]  wr_gnt;
  logic           rd_req = 1'b1;
  logic           rd_ack, rd_valid;
  logic           fifo_en, fifo_wr, fifo_rd;
  logic [DW-1:0]  fifo_din;
  logic           fifo_full, fifo_empty;

  int cnt   = 0;
  int depth = 8;
  int checks = 0;
  int errors = 0;

  assign wr_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  assign fifo_full  = (cnt >= depth);
  assign fifo_empty = (cnt == 0);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + (fifo_wr ? 1 : 0) - (fifo_rd ? 1 : 0);
  end

  fifo_arb #(
    .DWIDTH (DW),
    .NREQ   (NR),
    .BURST  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .fifo_en    (fifo_en),
    .fifo_wr    (fifo_wr),
    .fifo_rd    (fifo_rd),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, let combinational outputs settle.
  task automatic step(input logic r, input logic [NR-1:0] req, input logic rd);
    @(negedge clk);
    rst    = r;
    wr_req = req;
    rd_req = rd;
    #1;
  endtask

  logic [NR-1:0] burst_exp [9];
  logic [DW-1:0] din_exp;

  initial begin
    burst_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};

    // Reset holds every strobe low even with all requests up.
    @(negedge clk);
    #1;
    check("rst_gnt", 32'(wr_gnt), 32'h0);
    check("rst_ack", 32'(rd_ack), 32'h0);
    check("rst_en", 32'(fifo_en), 32'h0);
    check("rst_din", 32'(fifo_din), 32'h0);
    check("rst_valid", 32'(rd_valid), 32'h0);
    step(1'b0, 4'hF, 1'b1);
    check("rel_gnt", 32'(wr_gnt), 32'h1);
    check("rel_din", 32'(fifo_din), 32'hA0);
    check("rel_wr", 32'(fifo_wr), 32'h1);
    check("rel_rd", 32'(fifo_rd), 32'h0);

    // Burst of four per owner, two writers.
    depth = 16;
    step(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 4'b0011, 1'b0);
      check($sformatf("burst_gnt%0d", i), 32'(wr_gnt), 32'(burst_exp[i]));
      din_exp = (burst_exp[i] == 4'b0001) ? 8'hA0 : 8'hA1;
      check($sformatf("burst_din%0d", i), 32'(fifo_din), 32'(din_exp));
    end

    // Fill an 8-deep FIFO, stall on full, then one read frees one slot.
    depth = 8;
    step(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b0001, 1'b0);
      check($sformatf("fill_gnt%0d", i), 32'(wr_gnt), 32'h1);
    end
    step(1'b0, 4'b0001, 1'b0);
    check("full_gnt", 32'(wr_gnt), 32'h0);
    check("full_en", 32'(fifo_en), 32'h0);
    step(1'b0, 4'b0001, 1'b0);
    check("full_gnt2", 32'(wr_gnt), 32'h0);
    step(1'b0, 4'b0001, 1'b1);
    check("full_rdack", 32'(rd_ack), 32'h1);
    check("full_rd", 32'(fifo_rd), 32'h1);
    check("full_rdgnt", 32'(wr_gnt), 32'h0);
    step(1'b0, 4'b0001, 1'b0);
    check("full_valid", 32'(rd_valid), 32'h1);
    check("refill_gnt", 32'(wr_gnt), 32'h1);
    step(1'b0, 4'b0001, 1'b0);
    check("refull_gnt", 32'(wr_gnt), 32'h0);
    check("refull_valid", 32'(rd_valid), 32'h0);

    // Contention: two words held, writer 2 and reader alternate.
    step(1'b1, 4'h0, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    check("pre_gnt0", 32'(wr_gnt), 32'h4);
    step(1'b0, 4'b0100, 1'b0);
    check("pre_gnt1", 32'(wr_gnt), 32'h4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0100, 1'b1);
      check($sformatf("cont_gnt%0d", i), 32'(wr_gnt), (i % 2 == 0) ? 32'h4 : 32'h0);
      check($sformatf("cont_ack%0d", i), 32'(rd_ack), (i % 2 == 0) ? 32'h0 : 32'h1);
      check($sformatf("cont_both%0d", i), 32'(fifo_wr & fifo_rd), 32'h0);
      check($sformatf("cont_din%0d", i), 32'(fifo_din), (i % 2 == 0) ? 32'hA2 : 32'h0);
    end

    // Reset while writer 2 owns a burst at two beats, with a read just issued.
    step(1'b1, 4'h0, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    check("mid_gnt0", 32'(wr_gnt), 32'h4);
    step(1'b0, 4'b0100, 1'b1);
    check("mid_gnt1", 32'(wr_gnt), 32'h4);
    step(1'b0, 4'b0100, 1'b1);
    check("mid_rdack", 32'(rd_ack), 32'h1);
    step(1'b1, 4'b0101, 1'b0);
    check("mid_rst_gnt", 32'(wr_gnt), 32'h0);
    check("mid_rst_valid", 32'(rd_valid), 32'h1);
    step(1'b0, 4'b0101, 1'b0);
    check("mid_post_gnt", 32'(wr_gnt), 32'h1);
    check("mid_post_valid", 32'(rd_valid), 32'h0);

    // Reading an empty FIFO never acknowledges.
    step(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0, 1'b1);
      check($sformatf("empty_ack%0d", i), 32'(rd_ack), 32'h0);
      check($sformatf("empty_valid%0d", i), 32'(rd_valid), 32'h0);
      check($sformatf("empty_en%0d", i), 32'(fifo_en), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_arb.md
FIFO_ARB -- requirements
Module: fifo_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data width of each word.
REQ-002 SHALL have parameter NREQ, default 4, number of write requesters (2..8).
REQ-003 SHALL have parameter BURST, default 4, max consecutive writes granted to one owner (1..15).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_req  in  NREQ  per-requester write request, held until granted.
REQ-007 SHALL have port wr_data  in  NREQ*DWIDTH  requester i word in bits [i*DWIDTH +: DWIDTH], stable while wr_req[i] high.
REQ-008 SHALL have port wr_gnt  out  NREQ  one-hot or zero; wr_gnt[i]=1 means requester i's word is written at this edge.
REQ-009 SHALL have port rd_req  in  1  consumer read request, held until acknowledged.
REQ-010 SHALL have port rd_ack  out  1  read issued to the FIFO at this edge.
REQ-011 SHALL have port rd_valid  out  1  registered; FIFO dataOut holds the read word this cycle.
REQ-012 SHALL have ports fifo_en, fifo_wr, fifo_rd  out  1 each  FIFO command strobes.
REQ-013 SHALL have port fifo_din  out  DWIDTH  write data to FIFO.
REQ-014 SHALL have ports fifo_full, fifo_empty  in  1 each  FIFO status.

Function
REQ-015 SHALL issue at most one FIFO operation per cycle: fifo_en=fifo_wr|fifo_rd, never fifo_wr and fifo_rd together.
REQ-016 SHALL drive fifo_en, fifo_wr, fifo_rd, fifo_din, wr_gnt, rd_ack combinationally from current inputs and registered state (zero-latency grant).
REQ-017 SHALL treat a write as eligible only when some wr_req bit is high and fifo_full=0; a read as eligible only when rd_req=1 and fifo_empty=0.
REQ-018 SHALL, when both are eligible, choose by a registered turn bit (0=write, 1=read) and toggle it after each contended cycle; uncontended cycles leave it unchanged.
REQ-019 SHALL pick the writer round-robin: lowest index at or after rr_ptr among asserted wr_req, wrapping from NREQ-1 to 0.
REQ-020 SHALL have write FSM states IDLE and OWN; IDLE->OWN on a granted write (owner=winner, beats=1).
REQ-021 SHALL in OWN give priority to owner while wr_req[owner]=1 and beats<BURST, incrementing beats per granted write.
REQ-022 SHALL leave OWN->IDLE and set rr_ptr=(owner+1) mod NREQ when owner drops wr_req or beats reaches BURST.
REQ-023 SHALL hold OWN state and beats unchanged on cycles the write is blocked (full or read chosen).
REQ-024 SHALL drive fifo_din=wr_data slice of granted writer, else zero.
REQ-025 SHALL assert rd_valid exactly one cycle after each rd_ack cycle, low otherwise.
REQ-026 SHALL never grant a write while fifo_full=1 nor read while fifo_empty=1.

Reset
REQ-027 SHALL while rst=1 force wr_gnt=0, rd_ack=0, fifo_en=fifo_wr=fifo_rd=0, fifo_din=0.
REQ-028 SHALL at a rst edge set state=IDLE, rr_ptr=0, beats=0, turn=0, rd_valid=0, abandoning any burst mid-operation.
REQ-029 SHALL share rst with the FIFO so its count/pointers clear in the same cycle.

Structure
REQ-030 SHALL place state enum (IDLE, OWN) and default DWIDTH/NREQ/BURST constants in package fifo_arb_pkg.
REQ-031 SHALL implement round-robin selection in one combinational sub-module rr_pick (req vector, start pointer -> one-hot, valid).

Verification
REQ-032 Reset: rst=1 with all wr_req=4'hF, rd_req=1 -> no strobes; after release first grant wr_gnt=4'b0001.
REQ-033 Burst: wr_req=4'b0011 steady, BURST=4, FIFO not full -> grants 0,0,0,0,1,1,1,1,0...
REQ-034 Full: 8-deep FIFO, one writer -> 8 grants then wr_gnt=0 while fifo_full=1; rd_req=1 -> rd_ack, rd_valid next cycle, one further write.
REQ-035 Contention: FIFO holds 2 words, wr_req=4'b0100, rd_req=1 -> alternating write, read, write, read; fifo_wr&fifo_rd never both 1.
REQ-036 Mid-burst reset: owner 2 at beats=2, rst pulse -> next grant from rr_ptr=0 (wr_gnt=4'b0001 if requested), rd_valid=0.
REQ-037 Empty read: rd_req=1, fifo_empty=1, no writers -> rd_ack=0 and rd_valid=0 indefinitely.
